// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline slot and ALU operand select.
// Holds one decoded instruction and drives the ALU a/b/op inputs.
// It also detects load-use hazards, honours EX back-pressure and
// squashes the slot on a branch flush.
// Build option EX_FWD_EN:
//   - defined: EX/MEM and MEM/WB results are forwarded into the operands.
//   - undefined: operands come only from latched register-file data, and
//     decode stalls on any pending writer of one of its sources.
module ex_operand_stage #(
    parameter int REG_BITS = 4,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic [DATA_W-1:0]   id_rs1_data,
    input  logic [DATA_W-1:0]   id_rs2_data,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic                id_use_imm,
    input  logic [3:0]          id_alu_op,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_we,
    input  logic                id_is_load,
    output logic                id_stall,
    input  logic                ex_ready,
    input  logic                flush,
    input  logic [REG_BITS-1:0] exmem_rd,
    input  logic [REG_BITS-1:0] memwb_rd,
    input  logic                exmem_we,
    input  logic                memwb_we,
    input  logic [DATA_W-1:0]   exmem_data,
    input  logic [DATA_W-1:0]   memwb_data,
    input  logic                exmem_is_load,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_a,
    output logic [DATA_W-1:0]   ex_b,
    output logic [3:0]          ex_op,
    output logic [DATA_W-1:0]   ex_store_data,
    output logic [REG_BITS-1:0] ex_rd,
    output logic                ex_reg_we,
    output logic                ex_is_load
);

    logic                slot_valid;
    logic [REG_BITS-1:0] slot_rs1;
    logic [REG_BITS-1:0] slot_rs2;
    logic [DATA_W-1:0]   slot_rs1_data;
    logic [DATA_W-1:0]   slot_rs2_data;
    logic [DATA_W-1:0]   slot_imm;
    logic                slot_use_imm;
    logic [3:0]          slot_op;
    logic [REG_BITS-1:0] slot_rd;
    logic                slot_we;
    logic                slot_is_load;

    logic                load_use;
    logic                raw_hazard;
    logic                accept;
    logic [DATA_W-1:0]   rs1_value;
    logic [DATA_W-1:0]   rs2_value;
    logic                unused_inputs;

    // Load-use: a load sits in the slot and decode wants its result now
    always_comb begin
        load_use = 1'b0;
        if (slot_valid && slot_is_load && (slot_rd != '0) && id_valid &&
            ((slot_rd == id_rs1) || (slot_rd == id_rs2))) begin
            load_use = 1'b1;
        end else begin
            load_use = 1'b0;
        end
    end

`ifdef EX_FWD_EN
    // Youngest matching writer wins; r0 is hard-wired to zero.
    function automatic logic [DATA_W-1:0] fwd_value(
        input logic [REG_BITS-1:0] src,
        input logic [DATA_W-1:0]   latched,
        input logic                e_we,
        input logic [REG_BITS-1:0] e_rd,
        input logic [DATA_W-1:0]   e_data,
        input logic                m_we,
        input logic [REG_BITS-1:0] m_rd,
        input logic [DATA_W-1:0]   m_data
    );
        logic [DATA_W-1:0] value;
        if (src == '0) begin
            value = '0;
        end else if (e_we && (e_rd == src)) begin
            value = e_data;
        end else if (m_we && (m_rd == src)) begin
            value = m_data;
        end else begin
            value = latched;
        end
        return value;
    endfunction

    // With forwarding present, only load-use hazards stall decode.
    assign raw_hazard = 1'b0;
    // The load-use stall keeps a dependent instruction out of the slot while
    // its producer load is in EX/MEM, so exmem_is_load needs no extra gating.
    assign unused_inputs = exmem_is_load;

    // Operand forwarding from the two downstream stages
    always_comb begin
        rs1_value = fwd_value(slot_rs1, slot_rs1_data, exmem_we, exmem_rd,
                              exmem_data, memwb_we, memwb_rd, memwb_data);
        rs2_value = fwd_value(slot_rs2, slot_rs2_data, exmem_we, exmem_rd,
                              exmem_data, memwb_we, memwb_rd, memwb_data);
    end
`else
    // True when a non-zero source has a pending writer anywhere downstream.
    function automatic logic dest_hit(
        input logic [REG_BITS-1:0] src,
        input logic                s_we,
        input logic [REG_BITS-1:0] s_rd,
        input logic                e_we,
        input logic [REG_BITS-1:0] e_rd,
        input logic                m_we,
        input logic [REG_BITS-1:0] m_rd
    );
        logic hit;
        if (src == '0) begin
            hit = 1'b0;
        end else begin
            hit = (s_we && (s_rd == src)) || (e_we && (e_rd == src)) ||
                  (m_we && (m_rd == src));
        end
        return hit;
    endfunction

    // Without forwarding, decode waits until every pending writer has retired
    always_comb begin
        raw_hazard = 1'b0;
        if (id_valid &&
            (dest_hit(id_rs1, slot_valid & slot_we, slot_rd, exmem_we, exmem_rd,
                      memwb_we, memwb_rd) ||
             dest_hit(id_rs2, slot_valid & slot_we, slot_rd, exmem_we, exmem_rd,
                      memwb_we, memwb_rd))) begin
            raw_hazard = 1'b1;
        end else begin
            raw_hazard = 1'b0;
        end
    end

    // Downstream results are never used as operands in this build.
    assign unused_inputs = ^{exmem_data, memwb_data, exmem_is_load};

    // Operands straight from the latched register-file data, r0 reads zero
    always_comb begin
        rs1_value = (slot_rs1 == '0) ? '0 : slot_rs1_data;
        rs2_value = (slot_rs2 == '0) ? '0 : slot_rs2_data;
    end
`endif

    assign id_stall = ~ex_ready | load_use | raw_hazard;
    assign accept   = id_valid & ~id_stall & ~flush;

    // Pipeline slot: capture on ex_ready, hold otherwise; flush always squashes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid    <= 1'b0;
            slot_rs1      <= '0;
            slot_rs2      <= '0;
            slot_rs1_data <= '0;
            slot_rs2_data <= '0;
            slot_imm      <= '0;
            slot_use_imm  <= 1'b0;
            slot_op       <= 4'd0;
            slot_rd       <= '0;
            slot_we       <= 1'b0;
            slot_is_load  <= 1'b0;
        end else begin
            if (ex_ready) begin
                slot_rs1      <= id_rs1;
                slot_rs2      <= id_rs2;
                slot_rs1_data <= id_rs1_data;
                slot_rs2_data <= id_rs2_data;
                slot_imm      <= id_imm;
                slot_use_imm  <= id_use_imm;
                slot_rd       <= id_rd;
            end
            // accept is already low under flush, so this also loads the bubble
            if (ex_ready || flush) begin
                slot_valid   <= accept;
                slot_op      <= accept ? id_alu_op : 4'd0;
                slot_we      <= accept & id_reg_we;
                slot_is_load <= accept & id_is_load;
            end
        end
    end

    assign ex_valid      = slot_valid;
    assign ex_op         = slot_valid ? slot_op : 4'd0;
    assign ex_reg_we     = slot_valid & slot_we;
    assign ex_is_load    = slot_valid & slot_is_load;
    assign ex_rd         = slot_rd;
    assign ex_a          = rs1_value;
    assign ex_store_data = rs2_value;
    assign ex_b          = slot_use_imm ? slot_imm : rs2_value;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage. A reference slot model predicts
// the outputs each cycle; predictions are queued and popped against the DUT.
// A shadow EX/MEM/MEM-WB pipe and register file feed the downstream inputs.
// Works in both EX_FWD_EN builds.
module tb_ex_operand_stage;

`ifdef EX_FWD_EN
    localparam int EXP_RAW_STALLS = 0;
    localparam int EXP_LU_STALLS  = 1;
`else
    localparam int EXP_RAW_STALLS = 3;
    localparam int EXP_LU_STALLS  = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_rs1, id_rs2, id_rd, id_alu_op;
    logic [15:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_reg_we, id_is_load, id_stall;
    logic        ex_ready, flush;
    logic [3:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we, exmem_is_load;
    logic [15:0] exmem_data, memwb_data;
    logic        ex_valid, ex_reg_we, ex_is_load;
    logic [15:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_op, ex_rd;

    ex_operand_stage #(.REG_BITS(4), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .id_stall(id_stall), .ex_ready(ex_ready), .flush(flush),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .exmem_is_load(exmem_is_load), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [3:0]  rs1, rs2;
        logic [15:0] d1, d2, imm;
        logic        ui;
        logic [3:0]  op, rd;
        logic        we, ld;
    } slot_t;

    typedef struct packed {
        logic        full, v;
        logic [3:0]  op, rd;
        logic        we, ld, stall;
        logic [15:0] a, b, sd;
    } exp_t;

    slot_t       m;
    exp_t        sb[$];
    logic [15:0] rf[16];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        last_stall;
    int          st;
    logic [3:0]  nx_exmem_rd, nx_memwb_rd;
    logic        nx_exmem_we, nx_memwb_we, nx_exmem_is_load;
    logic [15:0] nx_exmem_data, nx_memwb_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] src_val(input logic [3:0] s, input logic [15:0] d);
        if (s == 4'd0) return 16'h0000;
`ifdef EX_FWD_EN
        if (exmem_we && exmem_rd == s) return exmem_data;
        if (memwb_we && memwb_rd == s) return memwb_data;
`endif
        return d;
    endfunction

    function automatic logic busy(input logic [3:0] s);
        return (s != 4'd0) && ((m.v && m.we && m.rd == s) ||
                               (exmem_we && exmem_rd == s) ||
                               (memwb_we && memwb_rd == s));
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.full  = 1'b0;
        e.v     = m.v;
        e.op    = m.v ? m.op : 4'd0;
        e.rd    = m.rd;
        e.we    = m.v & m.we;
        e.ld    = m.v & m.ld;
        e.a     = src_val(m.rs1, m.d1);
        e.sd    = src_val(m.rs2, m.d2);
        e.b     = m.ui ? m.imm : e.sd;
        e.stall = !ex_ready || (m.v && m.ld && m.rd != 4'd0 && id_valid &&
                                (m.rd == id_rs1 || m.rd == id_rs2));
`ifndef EX_FWD_EN
        if (id_valid && (busy(id_rs1) || busy(id_rs2))) e.stall = 1'b1;
`endif
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        check("ex_valid",   32'(ex_valid),   32'(e.v));
        check("ex_op",      32'(ex_op),      32'(e.op));
        check("ex_reg_we",  32'(ex_reg_we),  32'(e.we));
        check("ex_is_load", 32'(ex_is_load), 32'(e.ld));
        check("id_stall",   32'(id_stall),   32'(e.stall));
        if (e.full || e.v) begin
            check("ex_rd",         32'(ex_rd),         32'(e.rd));
            check("ex_a",          32'(ex_a),          32'(e.a));
            check("ex_b",          32'(ex_b),          32'(e.b));
            check("ex_store_data", 32'(ex_store_data), 32'(e.sd));
        end
    endtask

    task automatic load_fields();
        m.rs1 = id_rs1;      m.rs2 = id_rs2;
        m.d1  = id_rs1_data; m.d2  = id_rs2_data;
        m.imm = id_imm;      m.ui  = id_use_imm;
        m.rd  = id_rd;
    endtask

    // Called at the rising edge: retire into the shadow pipe and step the model.
    task automatic advance(input exp_t e);
        logic acc;
        nx_exmem_rd = exmem_rd; nx_exmem_we = exmem_we;
        nx_exmem_is_load = exmem_is_load; nx_exmem_data = exmem_data;
        nx_memwb_rd = memwb_rd; nx_memwb_we = memwb_we; nx_memwb_data = memwb_data;
        if (ex_ready) begin
            if (memwb_we && memwb_rd != 4'd0) rf[memwb_rd] = memwb_data;
            nx_memwb_rd = exmem_rd; nx_memwb_we = exmem_we; nx_memwb_data = exmem_data;
            nx_exmem_rd = e.rd; nx_exmem_we = e.we; nx_exmem_is_load = e.ld;
            nx_exmem_data = e.ld ? (16'hD000 | {12'h000, e.rd}) : (e.a + e.b);
        end
        acc = id_valid && !e.stall && !flush;
        if (flush) begin
            m.v = 1'b0; m.we = 1'b0; m.ld = 1'b0;
            if (ex_ready) begin
                load_fields();
                m.op = 4'd0;
            end
        end else if (ex_ready) begin
            load_fields();
            m.v  = acc;
            m.op = acc ? id_alu_op : 4'd0;
            m.we = acc ? id_reg_we : 1'b0;
            m.ld = acc ? id_is_load : 1'b0;
        end
    endtask

    task automatic step();
        exp_t e;
        #2;
        e = predict();
        sb.push_back(e);
        compare_out();
        last_stall = e.stall;
        @(posedge clk);
        advance(e);
        @(negedge clk);
        exmem_rd = nx_exmem_rd; exmem_we = nx_exmem_we;
        exmem_is_load = nx_exmem_is_load; exmem_data = nx_exmem_data;
        memwb_rd = nx_memwb_rd; memwb_we = nx_memwb_we; memwb_data = nx_memwb_data;
    endtask

    task automatic reset_check();
        exp_t e;
        #1;
        m = '0;
        exmem_rd = 4'd0; exmem_we = 1'b0; exmem_is_load = 1'b0; exmem_data = 16'h0000;
        memwb_rd = 4'd0; memwb_we = 1'b0; memwb_data = 16'h0000;
        #1;
        e = predict();
        e.full = 1'b1;
        sb.push_back(e);
        compare_out();
    endtask

    // Present one instruction, holding it while decode is stalled.
    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [15:0] imm, input logic ui,
                         input logic [3:0] op, input logic [3:0] rd,
                         input logic we, input logic ld, output int stalls);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_imm = imm; id_use_imm = ui;
        id_alu_op = op; id_rd = rd; id_reg_we = we; id_is_load = ld;
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            id_rs1_data = rf[rs1];
            id_rs2_data = rf[rs2];
            step();
            if (!last_stall) break;
            stalls++;
        end
        if (last_stall) check("stall_bound", 32'd1, 32'd0);
        id_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ex_ready = 1'b1; flush = 1'b0; id_valid = 1'b0;
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_rd = 4'd0; id_alu_op = 4'd0;
        id_rs1_data = 16'h0000; id_rs2_data = 16'h0000; id_imm = 16'h0000;
        id_use_imm = 1'b0; id_reg_we = 1'b0; id_is_load = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 16'(i * 256);
        @(negedge clk);
        @(negedge clk);
        reset_check();
        @(negedge clk);
        reset = 1'b0;

        // r1 = 0xBEEF, r1 = 0x1234, then r2 = r1 + r1 sees the younger value
        issue(4'd0, 4'd0, 16'hBEEF, 1'b1, 4'd1, 4'd1, 1'b1, 1'b0, st);
        issue(4'd0, 4'd0, 16'h1234, 1'b1, 4'd1, 4'd1, 1'b1, 1'b0, st);
        issue(4'd1, 4'd1, 16'h0000, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, st);
        check("raw_stalls", 32'(st), 32'(EXP_RAW_STALLS));
        #1;
        check("fwd_a", 32'(ex_a), 32'h1234);
        check("fwd_b", 32'(ex_b), 32'h1234);

        // LOAD r3 then SUB r4,r3,r5
        issue(4'd5, 4'd0, 16'h0004, 1'b1, 4'd2, 4'd3, 1'b1, 1'b1, st);
        issue(4'd3, 4'd5, 16'h0000, 1'b0, 4'd3, 4'd4, 1'b1, 1'b0, st);
        check("lu_stalls", 32'(st), 32'(EXP_LU_STALLS));
        #1;
        check("lu_a", 32'(ex_a), 32'hD003);
        check("lu_b", 32'(ex_b), 32'h0500);

        // Back-pressure: slot frozen for three cycles
        issue(4'd1, 4'd2, 16'h0000, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, st);
        ex_ready = 1'b0; id_valid = 1'b1; id_rs1 = 4'd6; id_rs2 = 4'd7;
        id_rd = 4'd11; id_alu_op = 4'd1; id_reg_we = 1'b1; id_is_load = 1'b0;
        id_use_imm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            check("hold_op", 32'(ex_op), 32'd1);
            check("hold_a", 32'(ex_a), 32'h1234);
            check("hold_rd", 32'(ex_rd), 32'd9);
            check("hold_stall", 32'(id_stall), 32'd1);
        end

        // Flush while frozen
        flush = 1'b1;
        step();
        #1;
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_we", 32'(ex_reg_we), 32'd0);
        flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
        step();

        // Write to r0 must never forward into an r0 source
        issue(4'd0, 4'd0, 16'hFFFF, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, st);
        issue(4'd0, 4'd0, 16'h0000, 1'b0, 4'd1, 4'd8, 1'b1, 1'b0, st);
        check("r0_stalls", 32'(st), 32'd0);
        #1;
        check("r0_a", 32'(ex_a), 32'h0000);
        check("r0_b", 32'(ex_b), 32'h0000);

        // Asynchronous reset with a valid instruction in the slot
        issue(4'd5, 4'd0, 16'h0001, 1'b1, 4'd1, 4'd10, 1'b1, 1'b0, st);
        #1;
        check("pre_reset_valid", 32'(ex_valid), 32'd1);
        reset = 1'b1;
        reset_check();
        @(negedge clk);
        reset = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU. It captures one decoded instruction per cycle and drives the ALU's `a`, `b` and `op` inputs. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards, stalling decode and inserting a bubble. It also honours downstream back-pressure and branch flush.

## Interface
Parameters:
- `REG_BITS`, 4: register index width (16 architectural registers; r0 reads as zero).
- `DATA_W`, 16: datapath width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode presents an instruction.
- `id_rs1`, `id_rs2` in `REG_BITS`: source register indices.
- `id_rs1_data`, `id_rs2_data` in `DATA_W`: register-file read data.
- `id_imm` in `DATA_W`: sign/zero-extended immediate.
- `id_use_imm` in 1: `b` operand comes from the immediate.
- `id_alu_op` in 4: ALU opcode.
- `id_rd` in `REG_BITS`: destination register.
- `id_reg_we` in 1: instruction writes `rd`.
- `id_is_load` in 1: instruction is a load.
- `id_stall` out 1: decode must hold its current instruction.
- `ex_ready` in 1: EX can accept; low freezes this stage.
- `flush` in 1: branch taken; squash the held and incoming instruction.
- `exmem_rd`, `memwb_rd` in `REG_BITS`: downstream destinations.
- `exmem_we`, `memwb_we` in 1: downstream write enables.
- `exmem_data`, `memwb_data` in `DATA_W`: downstream results.
- `exmem_is_load` in 1: EX/MEM holds a load, so its data is not yet valid.
- `ex_valid` out 1: `a`/`b`/`op` hold a real instruction.
- `ex_a`, `ex_b` out `DATA_W`: ALU operands.
- `ex_op` out 4: ALU opcode.
- `ex_store_data` out `DATA_W`: forwarded rs2 for stores.
- `ex_rd` out `REG_BITS`, `ex_reg_we` out 1, `ex_is_load` out 1: passed downstream.

## Operation
- State: one register slot holding valid, rs1, rs2, rs1/rs2 data, imm, use_imm, op, rd, we, is_load.
- Capture: on a rising edge with `ex_ready`=1, the slot loads the `id_*` fields. `valid` is set to `id_valid & ~id_stall & ~flush`. If that valid is 0, the slot holds a bubble: op=0, we=0, is_load=0.
- Hold: with `ex_ready`=0 the slot is unchanged, and `id_stall`=1.
- Flush: `flush`=1 clears `valid`, `we` and `is_load` at the next edge, even when `ex_ready`=0. `flush` has priority over hold and capture.
- Forwarding (combinational, per source `s`): select `exmem_data` if `exmem_we` and `exmem_rd`==`s`≠0. Otherwise select `memwb_data` if `memwb_we` and `memwb_rd`==`s`≠0. Otherwise use the latched register-file data.
  - Source index 0 always yields 0.
- Operand select: `ex_a` = forwarded rs1. `ex_b` = latched `imm` if `use_imm`, otherwise forwarded rs2. `ex_store_data` = forwarded rs2 regardless of `use_imm`.
- Load-use stall: `id_stall`=1 when `ex_is_load` & `ex_valid` & `ex_rd`≠0 & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`) & `id_valid`. The next edge then loads a bubble.
- Invalid slot: `ex_op`=0 and `ex_reg_we`=0. `ex_a`/`ex_b` are don't-care but must be deterministic.

## Timing
- Reset (async assert, sync-safe release) clears the slot: `ex_valid`=0, `ex_op`=0, `ex_rd`=0, `ex_reg_we`=0, `ex_is_load`=0, latched data and imm=0. Therefore `ex_a`=`ex_b`=`ex_store_data`=0 and `id_stall`=0.
- Latency: an instruction accepted at edge N is presented to the ALU during cycle N..N+1. Its forwarded operands reflect the EX/MEM and MEM/WB values of that same cycle.
- `id_stall` is combinational from slot state and the `id_*` inputs; no edge delay.
- Simultaneous `flush` and load-use stall: flush wins, the bubble is loaded, and `id_stall` follows the load-use rule.
- Both forward sources match the same register: EX/MEM wins as the younger instruction.

## Configuration
- `EX_FWD_EN` defined: the forwarding network is present, and stalls occur only for load-use.
- `EX_FWD_EN` undefined: no forwarding muxes, and operands come straight from latched register-file data.
  - `id_stall` asserts when any `id_valid` source (≠0) matches a valid, writing destination in `ex_rd`, `exmem_rd` or `memwb_rd`.
  - Bubbles are inserted until the hazard clears.

## Test plan
- Reset mid-stream with `ex_valid`=1 → the next sample shows `ex_valid`=0, `ex_op`=0, `ex_a`=0, with no clock needed.
- ADD r1 then ADD r2,r1,r1 with `exmem_rd`=1, `exmem_we`=1, `exmem_data`=0x1234 → `ex_a`=`ex_b`=0x1234. The same case also asserting `memwb_rd`=1 with data 0xBEEF still gives 0x1234.
- LOAD r3 in the slot, then decode SUB r4,r3,r5 → `id_stall`=1 for one cycle and a bubble enters. Next cycle `ex_a` = `memwb_data` for r3.
- `ex_ready`=0 for 3 cycles → `ex_op`, `ex_a` and `ex_rd` are unchanged, and `id_stall`=1 throughout.
- `flush`=1 while `ex_ready`=0 → `ex_valid`=0 and `ex_reg_we`=0 after the edge.
- Source r0 with `exmem_rd`=0, `exmem_we`=1, `exmem_data`=0xFFFF → `ex_a`=0. With `EX_FWD_EN` undefined, a dependent instruction stalls 3 cycles behind a writer.
